// File: rtl/axi_read_burst_responder.sv
// AXI4 read-slave responder: queues AR requests and streams FIXED/INCR/WRAP bursts from a preloadable word memory.
// Define AXI_RD_RESP_SLVERR_EN to answer out-of-range or oversize beats with SLVERR and zero data.

module axi_read_burst_responder #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 8,
    parameter int MEM_DEPTH     = 1024,
    parameter int AR_FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_WIDTH-1:0]        axi_ar_addr,
    input  logic [1:0]                   axi_ar_burst,
    input  logic [2:0]                   axi_ar_size,
    input  logic [ID_WIDTH-1:0]          axi_ar_id,
    input  logic [7:0]                   axi_ar_len,
    input  logic                         axi_ar_valid,
    output logic                         axi_ar_ready,
    output logic [DATA_WIDTH-1:0]        axi_r_data,
    output logic [ID_WIDTH-1:0]          axi_r_id,
    output logic [1:0]                   axi_r_resp,
    output logic                         axi_r_last,
    output logic                         axi_r_valid,
    input  logic                         axi_r_ready,
    input  logic                         mem_wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] mem_wr_addr,
    input  logic [DATA_WIDTH-1:0]        mem_wr_data
);

    localparam int LOG_BYTES = $clog2(DATA_WIDTH / 8);
    localparam int MEM_AW    = $clog2(MEM_DEPTH);
    localparam int FIFO_AW   = $clog2(AR_FIFO_DEPTH);
    localparam int CNT_W     = FIFO_AW + 1;

    typedef enum logic [1:0] { MODE_FIXED, MODE_INCR, MODE_WRAP } mode_t;
    typedef enum logic { IDLE, BEAT } state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [1:0]            burst;
        logic [2:0]            size;
        logic [ID_WIDTH-1:0]   id;
        logic [7:0]            len;
    } ar_req_t;

    ar_req_t               fifo_mem [AR_FIFO_DEPTH];
    logic [FIFO_AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  ar_push, ar_pop, fifo_empty;
    ar_req_t               head;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    state_t                state_q, state_d;
    logic                  load_first, load_next;

    logic [2:0]            head_es, wrap_shift;
    logic                  head_wrap_ok;
    logic [ADDR_WIDTH-1:0] head_bytes, head_span, head_boundary;
    mode_t                 head_mode;

    logic [ADDR_WIDTH-1:0] cur_addr_q, bytes_q, boundary_q, wrap_end_q;
    mode_t                 mode_q;
    logic [7:0]            len_q, beat_q;

    logic [ADDR_WIDTH-1:0] incr_addr, next_addr, beat_addr;
    logic [7:0]            beat_len, beat_idx;
    logic [MEM_AW-1:0]     word_idx;
    logic                  beat_err;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [1:0]            beat_resp;

    assign ar_push    = axi_ar_valid && axi_ar_ready;
    assign fifo_empty = (count_q == '0);
    assign head       = fifo_mem[rd_ptr];

    always_comb begin
        count_d = count_q;
        if (ar_push && !ar_pop)
            count_d = count_q + CNT_W'(1);
        else if (!ar_push && ar_pop)
            count_d = count_q - CNT_W'(1);
    end

    // Ready looks ahead at post-edge occupancy, so a simultaneous push and pop never drops it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            axi_ar_ready <= 1'b0;
        end else begin
            if (ar_push)
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (ar_pop)
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            count_q      <= count_d;
            axi_ar_ready <= (count_d < CNT_W'(AR_FIFO_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (ar_push)
            fifo_mem[wr_ptr] <= '{axi_ar_addr, axi_ar_burst, axi_ar_size, axi_ar_id, axi_ar_len};
    end

    always_ff @(posedge clk) begin
        if (mem_wr_en)
            mem[mem_wr_addr] <= mem_wr_data;
    end

    always_comb begin
        head_es      = (head.size > 3'(LOG_BYTES)) ? 3'(LOG_BYTES) : head.size;
        head_bytes   = ADDR_WIDTH'(1) << head_es;
        wrap_shift   = 3'd4;
        head_wrap_ok = 1'b1;
        case (head.len)
            8'd1:    wrap_shift = 3'd1;
            8'd3:    wrap_shift = 3'd2;
            8'd7:    wrap_shift = 3'd3;
            8'd15:   wrap_shift = 3'd4;
            default: head_wrap_ok = 1'b0;
        endcase
        head_span     = head_bytes << wrap_shift;
        head_boundary = head.addr & ~(head_span - ADDR_WIDTH'(1));
        case (head.burst)
            2'b00:   head_mode = MODE_FIXED;
            2'b10:   head_mode = head_wrap_ok ? MODE_WRAP : MODE_INCR;
            default: head_mode = MODE_INCR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // The last beat of one burst can hand straight over to the next queued burst.
    always_comb begin
        state_d    = state_q;
        ar_pop     = 1'b0;
        load_first = 1'b0;
        load_next  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    ar_pop     = 1'b1;
                    load_first = 1'b1;
                    state_d    = BEAT;
                end
            end
            BEAT: begin
                if (axi_r_ready) begin
                    if (!axi_r_last) begin
                        load_next = 1'b1;
                    end else if (!fifo_empty) begin
                        ar_pop     = 1'b1;
                        load_first = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign axi_r_valid = (state_q == BEAT);

    always_comb begin
        incr_addr = (cur_addr_q & ~(bytes_q - ADDR_WIDTH'(1))) + bytes_q;
        next_addr = incr_addr;
        case (mode_q)
            MODE_FIXED: next_addr = cur_addr_q;
            MODE_WRAP:  next_addr = (incr_addr == wrap_end_q) ? boundary_q : incr_addr;
            default:    next_addr = incr_addr;
        endcase
        beat_addr = load_first ? head.addr : next_addr;
        beat_len  = load_first ? head.len : len_q;
        beat_idx  = load_first ? 8'd0 : beat_q + 8'd1;
        word_idx  = MEM_AW'(beat_addr >> LOG_BYTES);
    end

`ifdef AXI_RD_RESP_SLVERR_EN
    logic oversize_q, head_oversize, out_of_range;
    assign head_oversize = (head.size > 3'(LOG_BYTES));
    assign out_of_range  = (((beat_addr >> LOG_BYTES) >> MEM_AW) != '0);
    assign beat_err      = out_of_range || (load_first ? head_oversize : oversize_q);
`else
    assign beat_err = 1'b0;
`endif

    assign beat_data = beat_err ? '0 : mem[word_idx];
    assign beat_resp = beat_err ? 2'b10 : 2'b00;

    // R outputs only move when a new beat is registered, which keeps them stable under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            axi_r_data <= '0;
            axi_r_id   <= '0;
            axi_r_resp <= 2'b00;
            axi_r_last <= 1'b0;
            cur_addr_q <= '0;
            bytes_q    <= '0;
            boundary_q <= '0;
            wrap_end_q <= '0;
            mode_q     <= MODE_INCR;
            len_q      <= '0;
            beat_q     <= '0;
`ifdef AXI_RD_RESP_SLVERR_EN
            oversize_q <= 1'b0;
`endif
        end else if (load_first || load_next) begin
            cur_addr_q <= beat_addr;
            beat_q     <= beat_idx;
            axi_r_data <= beat_data;
            axi_r_resp <= beat_resp;
            axi_r_last <= (beat_idx == beat_len);
            if (load_first) begin
                bytes_q    <= head_bytes;
                boundary_q <= head_boundary;
                wrap_end_q <= head_boundary + head_span;
                mode_q     <= head_mode;
                len_q      <= head.len;
                axi_r_id   <= head.id;
`ifdef AXI_RD_RESP_SLVERR_EN
                oversize_q <= head_oversize;
`endif
            end
        end else if (state_d == IDLE) begin
            axi_r_last <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_read_burst_responder.sv
// Randomized self-checking bench for axi_read_burst_responder against a burst-level reference model.

module tb_axi_read_burst_responder;

    localparam int ADDR_WIDTH    = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int ID_WIDTH      = 8;
    localparam int MEM_DEPTH     = 1024;
    localparam int AR_FIFO_DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [ADDR_WIDTH-1:0] axi_ar_addr;
    logic [1:0]            axi_ar_burst;
    logic [2:0]            axi_ar_size;
    logic [ID_WIDTH-1:0]   axi_ar_id;
    logic [7:0]            axi_ar_len;
    logic                  axi_ar_valid;
    logic                  axi_ar_ready;
    logic [DATA_WIDTH-1:0] axi_r_data;
    logic [ID_WIDTH-1:0]   axi_r_id;
    logic [1:0]            axi_r_resp;
    logic                  axi_r_last;
    logic                  axi_r_valid;
    logic                  axi_r_ready;
    logic                  mem_wr_en;
    logic [9:0]            mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;

    axi_read_burst_responder #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .ID_WIDTH(ID_WIDTH),
        .MEM_DEPTH(MEM_DEPTH), .AR_FIFO_DEPTH(AR_FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .axi_ar_addr(axi_ar_addr), .axi_ar_burst(axi_ar_burst), .axi_ar_size(axi_ar_size),
        .axi_ar_id(axi_ar_id), .axi_ar_len(axi_ar_len), .axi_ar_valid(axi_ar_valid),
        .axi_ar_ready(axi_ar_ready),
        .axi_r_data(axi_r_data), .axi_r_id(axi_r_id), .axi_r_resp(axi_r_resp),
        .axi_r_last(axi_r_last), .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
    );

    typedef struct {
        logic [31:0] data;
        logic [7:0]  id;
        logic        last;
        logic [1:0]  resp;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       mon_b;
    logic [31:0] model_mem [MEM_DEPTH];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc_cnt  = 0;
    int          hs_cycle = 0;
    int          first_hs = 0;
    bit          rand_done = 1'b0;
    int          rc;
    logic [31:0] rnd_addr;
    logic [1:0]  rnd_burst;
    logic [2:0]  rnd_size;
    logic [7:0]  rnd_len;
    logic [63:0] cur_r, prev_r;
    bit          prev_stall = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    assign cur_r = {20'd0, axi_r_valid, axi_r_last, axi_r_resp, axi_r_id, axi_r_data};

    task automatic check_output(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: lists every beat of a burst straight from the addressing rules.
    task automatic push_expected(input logic [31:0] start, input logic [1:0] burst,
                                 input logic [2:0] size, input logic [7:0] id, input logic [7:0] len);
        int unsigned es, bytes, span, bnd, a, word;
        bit          wrap, fixed, err;
        beat_t       b;
        es    = (size > 3'd2) ? 2 : int'(size);
        bytes = 1 << es;
        fixed = (burst == 2'b00);
        wrap  = (burst == 2'b10) && (len == 1 || len == 3 || len == 7 || len == 15);
        span  = bytes * (int'(len) + 1);
        bnd   = (start / span) * span;
        for (int i = 0; i <= int'(len); i++) begin
            if (fixed || i == 0) begin
                a = start;
            end else begin
                a = (start / bytes) * bytes + i * bytes;
                if (wrap && a >= bnd + span)
                    a = a - span;
            end
            word = a >> 2;
            err  = 1'b0;
`ifdef AXI_RD_RESP_SLVERR_EN
            err = (word >= MEM_DEPTH) || (size > 3'd2);
`endif
            b.data = err ? 32'd0 : model_mem[word % MEM_DEPTH];
            b.resp = err ? 2'b10 : 2'b00;
            b.id   = id;
            b.last = (i == int'(len));
            exp_q.push_back(b);
        end
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [1:0] burst,
                           input logic [2:0] size, input logic [7:0] id, input logic [7:0] len);
        int waited = 0;
        axi_ar_addr  = addr;
        axi_ar_burst = burst;
        axi_ar_size  = size;
        axi_ar_id    = id;
        axi_ar_len   = len;
        axi_ar_valid = 1'b1;
        @(negedge clk);
        while (!axi_ar_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!axi_ar_ready) begin
            check_output("ar_ready_timeout", axi_ar_ready, 1);
            axi_ar_valid = 1'b0;
            return;
        end
        @(posedge clk);
        hs_cycle = cyc_cnt;
        push_expected(addr, burst, size, id, len);
        #1 axi_ar_valid = 1'b0;
    endtask

    task automatic write_mem(input int idx, input logic [31:0] data);
        mem_wr_en   = 1'b1;
        mem_wr_addr = 10'(idx);
        mem_wr_data = data;
        @(posedge clk);
        #1 mem_wr_en = 1'b0;
        model_mem[idx] = data;
    endtask

    task automatic wait_drain();
        int c = 0;
        while ((exp_q.size() != 0 || axi_r_valid) && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
        end
        if (c >= 2000)
            check_output("drain_timeout", exp_q.size(), 0);
    endtask

    // Beat monitor: compares every accepted beat with the model and checks hold under stall.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall)
                    check_output("r_stable", cur_r, prev_r);
                if (axi_r_valid && exp_q.size() == 0)
                    check_output("beat_expected", 0, 1);
                else if (axi_r_valid && axi_r_ready) begin
                    mon_b = exp_q.pop_front();
                    check_output("r_data", axi_r_data, mon_b.data);
                    check_output("r_id", axi_r_id, mon_b.id);
                    check_output("r_last", axi_r_last, mon_b.last);
                    check_output("r_resp", axi_r_resp, mon_b.resp);
                end
                prev_stall = axi_r_valid && !axi_r_ready;
                prev_r     = cur_r;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        axi_ar_addr  = '0;
        axi_ar_burst = 2'b01;
        axi_ar_size  = 3'd2;
        axi_ar_id    = '0;
        axi_ar_len   = '0;
        axi_ar_valid = 1'b0;
        axi_r_ready  = 1'b0;
        mem_wr_en    = 1'b0;
        mem_wr_addr  = '0;
        mem_wr_data  = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_ar_ready", axi_ar_ready, 0);
        check_output("rst_r_valid", axi_r_valid, 0);
        check_output("rst_r_last", axi_r_last, 0);
        check_output("rst_r_data", axi_r_data, 0);
        check_output("rst_r_id", axi_r_id, 0);
        check_output("rst_r_resp", axi_r_resp, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_output("ar_ready_pre_edge", axi_ar_ready, 0);
        @(negedge clk);
        check_output("ar_ready_post_reset", axi_ar_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < MEM_DEPTH; i++)
            write_mem(i, 32'h1000_0000 + i);

        // INCR burst with first-beat latency
        axi_r_ready = 1'b1;
        send_ar(32'h10, 2'b01, 3'd2, 8'd5, 8'd3);
        @(negedge clk);
        check_output("latency_edge_n", axi_r_valid, 0);
        @(negedge clk);
        check_output("latency_edge_n1", axi_r_valid, 1);
        check_output("incr_first_data", axi_r_data, 32'h1000_0004);
        wait_drain();

        send_ar(32'h38, 2'b10, 3'd2, 8'd6, 8'd3);
        wait_drain();
        send_ar(32'h20, 2'b00, 3'd2, 8'd7, 8'd2);
        wait_drain();

        // Backpressure held for three edges on beat 1
        send_ar(32'h10, 2'b01, 3'd2, 8'd8, 8'd3);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 axi_r_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_output("bp_hold_valid", axi_r_valid, 1);
        check_output("bp_hold_data", axi_r_data, 32'h1000_0005);
        axi_r_ready = 1'b1;
        wait_drain();

        // Write on the edge that registers the beat must not be seen by it
        send_ar(32'h40, 2'b01, 3'd2, 8'd9, 8'd0);
        mem_wr_en   = 1'b1;
        mem_wr_addr = 10'd16;
        mem_wr_data = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 mem_wr_en = 1'b0;
        model_mem[16] = 32'hDEAD_BEEF;
        wait_drain();
        send_ar(32'h40, 2'b01, 3'd2, 8'd10, 8'd0);
        wait_drain();

        // Queue fill with R stalled, then bubble-free drain
        axi_r_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            send_ar(32'(k * 4), 2'b01, 3'd2, 8'(8'h20 + k), 8'd0);
            if (k == 0)
                first_hs = hs_cycle;
        end
        check_output("queue_back_to_back", hs_cycle - first_hs, 4);
        @(negedge clk);
        check_output("queue_full_ready", axi_ar_ready, 0);
        @(posedge clk);
        #1 axi_r_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_output("queue_no_bubble", axi_r_valid, 1);
        end
        @(negedge clk);
        check_output("queue_drained", axi_r_valid, 0);
        check_output("queue_ready_back", axi_ar_ready, 1);
        @(posedge clk);
        #1;

        send_ar(32'(4 * MEM_DEPTH), 2'b01, 3'd2, 8'h33, 8'd1);
        wait_drain();

        // Randomized traffic with random R backpressure
        rand_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    rnd_addr  = $urandom_range(0, 8191);
                    rnd_burst = 2'($urandom_range(0, 3));
                    rnd_size  = 3'($urandom_range(0, 3));
                    if (rnd_burst == 2'b10 && $urandom_range(0, 1) == 1) begin
                        case ($urandom_range(0, 3))
                            0:       rnd_len = 8'd1;
                            1:       rnd_len = 8'd3;
                            2:       rnd_len = 8'd7;
                            default: rnd_len = 8'd15;
                        endcase
                    end else begin
                        rnd_len = 8'($urandom_range(0, 15));
                    end
                    send_ar(rnd_addr, rnd_burst, rnd_size, 8'($urandom_range(0, 255)), rnd_len);
                end
                rand_done = 1'b1;
            end
            begin
                rc = 0;
                while ((!rand_done || exp_q.size() != 0) && rc < 5000) begin
                    @(posedge clk);
                    #1 axi_r_ready = ($urandom_range(0, 3) != 0);
                    rc++;
                end
                axi_r_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset in the middle of a burst with another request queued
        axi_r_ready = 1'b0;
        send_ar(32'h0, 2'b01, 3'd2, 8'h44, 8'd7);
        send_ar(32'h100, 2'b01, 3'd2, 8'h45, 8'd3);
        @(negedge clk);
        check_output("pre_reset_valid", axi_r_valid, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        @(negedge clk);
        check_output("mid_reset_r_valid", axi_r_valid, 0);
        check_output("mid_reset_ar_ready", axi_ar_ready, 0);
        check_output("mid_reset_r_last", axi_r_last, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        axi_r_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_output("abandoned_r_valid", axi_r_valid, 0);
        end
        check_output("post_reset_ar_ready", axi_ar_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_read_burst_responder.md
# axi_read_burst_responder

Synthesizable AXI4 read-slave responder that sits directly downstream of the testbench read-channel driver: it accepts AR requests, queues them, and returns R bursts whose data comes from an internal word memory. FIXED, INCR and WRAP address sequencing are supported, with one beat per cycle and no bubbles between queued bursts. A side-band write port preloads the memory so the bench can predict every returned beat.

## Interface
Parameters:
- ADDR_WIDTH, 32, AR address width
- DATA_WIDTH, 32, R data width; power of two, 8 to 1024
- ID_WIDTH, 8, AR/R ID width
- MEM_DEPTH, 1024, memory depth in DATA_WIDTH words; power of two
- AR_FIFO_DEPTH, 4, queued AR requests; power of two, at least 2

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- axi_ar_addr  in  ADDR_WIDTH  start byte address
- axi_ar_burst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- axi_ar_size  in  3  log2 of bytes per beat
- axi_ar_id  in  ID_WIDTH  transaction ID
- axi_ar_len  in  8  beats minus 1
- axi_ar_valid  in  1  AR valid
- axi_ar_ready  out  1  AR ready
- axi_r_data  out  DATA_WIDTH  read data
- axi_r_id  out  ID_WIDTH  echoed ID
- axi_r_resp  out  2  response code
- axi_r_last  out  1  final beat of burst
- axi_r_valid  out  1  R valid
- axi_r_ready  in  1  R ready
- mem_wr_en  in  1  preload write enable
- mem_wr_addr  in  log2(MEM_DEPTH)  preload word index
- mem_wr_data  in  DATA_WIDTH  preload data

## Operation
- **AR FIFO**
  - Handshake is axi_ar_valid && axi_ar_ready.
  - axi_ar_ready is registered. It equals 1 when the FIFO will have at least one free entry after the current edge.
  - A push and a pop in the same cycle on a full FIFO keeps axi_ar_ready at 1.
- **Burst engine FSM**
  - IDLE -> BEAT when the FIFO is non-empty. The FSM pops the FIFO and registers beat 0 into the R outputs.
  - BEAT holds while axi_r_valid && !axi_r_ready.
  - On an accepted non-last beat, the next beat is registered.
  - On an accepted last beat: if the FIFO is non-empty, pop it and register the next burst's beat 0 on the same edge (stay in BEAT). Otherwise go to IDLE with axi_r_valid = 0.
- **Addressing**
  - Effective size: es = min(axi_ar_size, log2(DATA_WIDTH/8)); bytes = 1 << es.
  - FIXED: every beat uses the start address.
  - INCR: beat 0 uses the start address. Beat i uses the start address aligned down to bytes, plus i*bytes.
  - WRAP: legal when len is 1, 3, 7 or 15. Span = bytes*(len+1); the address wraps to floor(start/span)*span when it reaches boundary+span. A WRAP with any other len is treated as INCR.
  - Burst 11 is treated as INCR.
  - Address arithmetic is ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH.
- **Data and metadata**
  - Word index = (address >> log2(DATA_WIDTH/8)) mod MEM_DEPTH.
  - axi_r_data is the full memory word; lane selection is the master's job.
  - axi_r_last = 1 exactly on beat len.
  - axi_r_id = the burst's ID.
  - axi_r_resp = 00 (OKAY), unless the configuration feature below applies.
- **Memory**
  - Single write port, asynchronous-read array; not reset.
  - mem_wr_en writes mem_wr_data at the edge.

## Timing
- **Reset** (rst high at an edge). Next cycle:
  - axi_ar_ready = 0, axi_r_valid = 0, axi_r_last = 0.
  - axi_r_data, axi_r_id, axi_r_resp = 0.
  - FIFO empty, FSM in IDLE.
  - axi_ar_ready rises on the first edge with rst low.
  - Reset mid-burst abandons the burst and all queued requests.
- **Latency.** An AR handshake at edge N gives axi_r_valid = 1 after edge N+1, when the FSM is IDLE.
- **Throughput.** One beat per cycle while axi_r_ready = 1, including across burst boundaries.
- **Stability.** While axi_r_valid && !axi_r_ready, all R outputs are held unchanged.
- **Beat data sampling.**
  - Beat data is sampled from memory at the edge that registers the beat.
  - A mem_wr_en to the same word on that edge is not visible in that beat.
  - The write is visible to beats registered on later edges.

## Configuration
- AXI_RD_RESP_SLVERR_EN defined:
  - A beat whose word index (address >> log2(DATA_WIDTH/8)) is at least MEM_DEPTH returns axi_r_resp = 10 (SLVERR) and axi_r_data = 0.
  - A burst with axi_ar_size > log2(DATA_WIDTH/8) returns SLVERR on every beat.
  - In both cases the burst length and axi_r_last are unchanged.
- Not defined: axi_r_resp is always 00, out-of-range addresses alias modulo MEM_DEPTH, and oversize is clamped.

## Test plan
- **Preload and INCR.** Preload mem[i] = 0x1000_0000 + i. Send AR addr 0x10, INCR, size 2, len 3, id 5, with r_ready = 1. Expect data 0x10000004..0x10000007 and id 5; last only on beat 3; r_valid 2 cycles after AR.
- **WRAP.** Send AR addr 0x38, WRAP, size 2, len 3. Expect words 0x0E, 0x0F, 0x0C, 0x0D.
- **FIXED.** Send AR addr 0x20, len 2. Expect data 0x10000008 three times.
- **Backpressure.** On the INCR burst, hold r_ready low for 3 cycles at beat 1. R outputs stay constant; after release the remaining beats arrive in order.
- **Queue.** Send 5 back-to-back ARs (len 0) with r_ready = 0 and AR_FIFO_DEPTH = 4. axi_ar_ready drops after 4 accepts plus the engine pop. After r_ready = 1, five consecutive single beats arrive with no bubble and the correct IDs.
- **Out-of-range.** With AXI_RD_RESP_SLVERR_EN, send AR addr 4*MEM_DEPTH, len 1. Expect resp 10 and data 0 on both beats. Without the macro, expect data 0x10000000 and 0x10000001 with resp 00.
